// File: rtl/alu_pipe.sv
`default_nettype none
// -----------------------------------------------------------------------------
// alu_pipe : handshaked 16-opcode ALU with registered result and flags.
// Macro ALU_PIPE_MUL_EN makes opcode 15 a WIDTH-cycle unsigned shift-add multiply.
// Revision 1.0
// -----------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             zero
);
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic [3:0]       flags_q, flags_d;
  logic             zero_q, zero_d;

  logic             accept;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] op_result;
  logic [3:0]       op_flags;

`ifdef ALU_PIPE_MUL_EN
  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] prod_q, prod_d, prod_next;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     mul_sum;

  // Add the multiplicand into the high half when the current multiplier bit is set, then shift right.
  assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_next = {mul_sum, prod_q[WIDTH-1:1]};
`endif

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // The extra MSB holds add carry-out and subtract borrow respectively.
  assign add_full = {1'b0, a} + {1'b0, b};
  assign sub_full = {1'b0, a} - {1'b0, b};

  always_comb begin
    op_result = ONE_W;
    op_flags  = 4'b0000;
    case (select)
      4'd0: begin
        op_result   = add_full[WIDTH-1:0];
        op_flags[0] = add_full[WIDTH];
      end
      4'd1: begin
        op_result   = sub_full[WIDTH-1:0];
        op_flags[1] = sub_full[WIDTH];
      end
      4'd2:  op_result = a & b;
      4'd3:  op_result = a | b;
      4'd4:  op_result = ~a;
      4'd5:  op_result = a ^ b;
      4'd6:  op_result = ~(a ^ b);
      4'd7:  op_result = ~(a | b);
      4'd8:  op_result = ~(a & b);
      4'd9:  op_result = ~a + ONE_W;
      4'd10: op_result = {a[WIDTH-2:0], 1'b0};
      4'd11: op_result = {1'b0, a[WIDTH-1:1]};
      4'd12: op_result = a;
      4'd13: begin
        op_result   = a + ONE_W;
        op_flags[2] = &a;
      end
      4'd14: begin
        op_result   = a - ONE_W;
        op_flags[3] = ~|a;
      end
      default: op_result = ONE_W;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    zero_d      = zero_q;
`ifdef ALU_PIPE_MUL_EN
    prod_d      = prod_q;
    mcand_d     = mcand_q;
    cnt_d       = cnt_q;
`endif
    if (accept) begin
`ifdef ALU_PIPE_MUL_EN
      if (select == 4'd15) begin
        state_d = BUSY;
        mcand_d = a;
        prod_d  = {{WIDTH{1'b0}}, b};
        cnt_d   = '0;
      end else
`endif
      begin
        state_d     = DONE;
        result_d    = op_result;
        result_hi_d = '0;
        flags_d     = op_flags;
        zero_d      = (op_result == '0);
      end
    end else if ((state_q == DONE) && out_ready) begin
      state_d = IDLE;
    end
`ifdef ALU_PIPE_MUL_EN
    else if (state_q == BUSY) begin
      prod_d = prod_next;
      cnt_d  = cnt_q + CNT_W'(1);
      // Final iteration loads the product straight into the output registers.
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        state_d     = DONE;
        result_d    = prod_next[WIDTH-1:0];
        result_hi_d = prod_next[2*WIDTH-1:WIDTH];
        flags_d     = {3'b000, |prod_next[2*WIDTH-1:WIDTH]};
        zero_d      = (prod_next[WIDTH-1:0] == '0);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      zero_q      <= zero_d;
    end
  end

`ifdef ALU_PIPE_MUL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end
`endif

  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flags     = flags_q;
  assign zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_alu_pipe : self-checking bench for alu_pipe (WIDTH=32 scoreboard, WIDTH=8 spot checks).
// Revision 1.0
// -----------------------------------------------------------------------------
module tb_alu_pipe;
  localparam int W = 32;
`ifdef ALU_PIPE_MUL_EN
  localparam bit MUL = 1'b1;
`else
  localparam bit MUL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, zero;
  logic [W-1:0] a = '0, b = '0, result, result_hi;
  logic [3:0]   select = '0, flags;

  logic         in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1, zero8;
  logic [7:0]   a8 = '0, b8 = '0, result8, result_hi8;
  logic [3:0]   select8 = '0, flags8;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .select(select), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .flags(flags), .zero(zero)
  );

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .select(select8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .result_hi(result_hi8), .flags(flags8), .zero(zero8)
  );

  typedef struct {
    logic [3:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [3:0]   flg;
    logic         z;
  } vec_t;

  vec_t exp_q[$];
  vec_t vecs[$];
  vec_t cur;
  vec_t got;
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(logic [3:0] s, logic [W-1:0] va, logic [W-1:0] vb,
                              logic [W-1:0] r, logic [W-1:0] h, logic [3:0] f, logic z);
    vec_t v;
    v.sel = s; v.a = va; v.b = vb; v.res = r; v.hi = h; v.flg = f; v.z = z;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pop on an output handshake, push on an input handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          got = exp_q.pop_front();
          check($sformatf("res_op%0d", got.sel), 64'(result), 64'(got.res));
          check($sformatf("hi_op%0d", got.sel), 64'(result_hi), 64'(got.hi));
          check($sformatf("flags_op%0d", got.sel), 64'(flags), 64'(got.flg));
          check($sformatf("zero_op%0d", got.sel), 64'(zero), 64'(got.z));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(cur);
    end
  end

  task automatic drive(input vec_t v);
    cur = v; select = v.sel; a = v.a; b = v.b; in_valid = 1'b1;
  endtask

  task automatic send(input vec_t v);
    int n = 0;
    drive(v);
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic latency(input string name, input vec_t v, input int exp_k);
    int k = 0;
    send(v);
    while (!out_valid && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, 64'(k), 64'(exp_k));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t mulv;
    int   stale;
    mulv = MUL ? mk(4'd15, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 32'h1, 4'b0001, 1'b0)
               : mk(4'd15, 32'hFFFFFFFF, 32'h2, 32'h1, 32'h0, 4'b0000, 1'b0);

    vecs.push_back(mk(4'd0,  32'hFFFFFFFF, 32'h1,        32'h0,        '0, 4'b0001, 1'b1));
    vecs.push_back(mk(4'd1,  32'h3,        32'h5,        32'hFFFFFFFE, '0, 4'b0010, 1'b0));
    vecs.push_back(mk(4'd14, 32'h0,        32'h0,        32'hFFFFFFFF, '0, 4'b1000, 1'b0));
    vecs.push_back(mk(4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, '0, 4'b0000, 1'b0));
    vecs.push_back(mk(4'd3,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, '0, 4'b0000, 1'b0));
    vecs.push_back(mk(4'd4,  32'h12345678, 32'h0,        32'hEDCBA987, '0, 4'b0000, 1'b0));
    vecs.push_back(mk(4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, '0, 4'b0000, 1'b0));
    vecs.push_back(mk(4'd6,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF00FF00F, '0, 4'b0000, 1'b0));
    vecs.push_back(mk(4'd7,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, '0, 4'b0000, 1'b0));
    vecs.push_back(mk(4'd8,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, '0, 4'b0000, 1'b0));
    vecs.push_back(mk(4'd9,  32'h1,        32'h0,        32'hFFFFFFFF, '0, 4'b0000, 1'b0));
    vecs.push_back(mk(4'd10, 32'h80000001, 32'h0,        32'h00000002, '0, 4'b0000, 1'b0));
    vecs.push_back(mk(4'd11, 32'h80000001, 32'h0,        32'h40000000, '0, 4'b0000, 1'b0));
    vecs.push_back(mk(4'd12, 32'h0,        32'hFFFFFFFF, 32'h0,        '0, 4'b0000, 1'b1));
    vecs.push_back(mk(4'd13, 32'hFFFFFFFF, 32'h0,        32'h0,        '0, 4'b0100, 1'b1));
    vecs.push_back(mk(4'd13, 32'h5,        32'h0,        32'h6,        '0, 4'b0000, 1'b0));
    vecs.push_back(mk(4'd14, 32'h1,        32'h0,        32'h0,        '0, 4'b0000, 1'b1));
    vecs.push_back(mk(4'd0,  32'h2,        32'h3,        32'h5,        '0, 4'b0000, 1'b0));
    vecs.push_back(mk(4'd1,  32'h5,        32'h3,        32'h2,        '0, 4'b0000, 1'b0));
    vecs.push_back(mk(4'd1,  32'h5,        32'h5,        32'h0,        '0, 4'b0000, 1'b1));
    vecs.push_back(mulv);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_result_hi", 64'(result_hi), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back table vectors with out_ready held high
    foreach (vecs[i]) send(vecs[i]);
    drain();

    // Latency: single-cycle op visible right after the accepting edge; multiply WIDTH edges later
    latency("lat_single", vecs[0], 0);
    drain();
    latency("lat_op15", mulv, MUL ? W : 0);
    drain();

    // Back-pressure: result held, in_ready low, then new op accepted on the release edge
    out_ready = 1'b0;
    send(mk(4'd5, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, '0, 4'b0000, 1'b0));
    for (int i = 0; i < 3; i++) begin
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_hold_result", 64'(result), 64'h0FF00FF0);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      if (i == 0) drive(mk(4'd12, 32'h55, 32'h0, 32'h55, '0, 4'b0000, 1'b0));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_new_valid", 64'(out_valid), 64'd1);
    check("bp_new_result", 64'(result), 64'h55);
    drain();

    // WIDTH=8 instance
    a8 = 8'hFF; select8 = 4'd13; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    check("w8_inc_valid", 64'(out_valid8), 64'd1);
    check("w8_inc_result", 64'(result8), 64'h00);
    check("w8_inc_flags", 64'(flags8), 64'b0100);
    check("w8_inc_zero", 64'(zero8), 64'd1);
    a8 = 8'h81; select8 = 4'd10; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    check("w8_shl_result", 64'(result8), 64'h02);
    check("w8_shl_flags", 64'(flags8), 64'd0);
    check("w8_shl_zero", 64'(zero8), 64'd0);

    // Reset ten cycles after accepting opcode 15 aborts it with no stale result
    out_ready = 1'b0;
    send(mulv);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_result_hi", 64'(result_hi), 64'd0);
    check("abort_flags", 64'(flags), 64'd0);
    check("abort_zero", 64'(zero), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    stale = 0;
    for (int i = 0; i < W + 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("abort_no_stale_valid", 64'(stale), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
